vector_store_serializer: RTL and testbench

Consumes a vector result (LANES x DATA_WIDTH plus a lane mask) from the vector ALU/register file. Writes only the enabled lanes to the byte-wide data memory, one element per accepted memory cycle. It is the store-side counterpart of the vector operand path: the ALU produces whole vectors, and this block drains them lane-by-lane to memory. It sits between the vector writeback stage and the data-memory write port.

---
 rtl/vector_pkg.sv | 23 ++
 rtl/lane_priority_encoder.sv | 30 +++
 rtl/vector_store_serializer.sv | 209 ++++++++++++++++++++
 tb/tb_vector_store_serializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// ---------------------------------------------------------------------------
// vector_pkg
// Shared definitions for the vector store path: default geometry of a vector
// (lane count, element width, address width), the lane/vector types, and the
// state encoding used by vector_store_serializer.
// No ports; imported with "import vector_pkg::*;".
// ---------------------------------------------------------------------------
package vector_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_LANES      = 6;
    localparam int DEFAULT_ADDR_WIDTH = 16;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] lane_t;
    typedef lane_t [DEFAULT_LANES-1:0]     vec_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } vstore_state_t;

endpackage

// File: rtl/lane_priority_encoder.sv
// ---------------------------------------------------------------------------
// lane_priority_encoder
// Purely combinational: returns the index of the lowest set bit of a lane
// mask, so lanes are always drained in ascending order.
// Ports:
//   pending_i  in   LANES   lanes still waiting to be stored
//   index_o    out  IDX_W   lowest-indexed set lane (0 when none set)
//   any_o      out  1       at least one lane is set
// ---------------------------------------------------------------------------
module lane_priority_encoder #(
    parameter int LANES = 6,
    parameter int IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES-1:0] pending_i,
    output logic [IDX_W-1:0] index_o,
    output logic             any_o
);

    // Scan from the top down so the last hit, the lowest set lane, wins.
    always_comb begin
        index_o = '0;
        any_o   = |pending_i;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (pending_i[i]) begin
                index_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/vector_store_serializer.sv
// ---------------------------------------------------------------------------
// vector_store_serializer
// Drains a whole vector result into byte-wide data memory, one enabled lane
// per accepted memory write, lowest lane first. Disabled lanes take no cycles.
// After the last write (or straight away for an empty mask) a single DONE
// cycle pulses 'done' before the block returns to IDLE.
//
// Optional build macro: VSTORE_STRIDE_EN adds a 'stride' input; lane k is then
// written to base + k*stride. Without it lane k goes to base + k.
//
// Ports:
//   clk          in   1                   system clock, rising edge
//   reset        in   1                   asynchronous active-high reset
//   start_valid  in   1                   request to store a vector
//   start_ready  out  1                   request can be accepted (IDLE)
//   base_addr    in   ADDR_WIDTH          address of lane 0
//   stride       in   ADDR_WIDTH          lane address step (VSTORE_STRIDE_EN)
//   data_in      in   LANES*DATA_WIDTH    packed vector, lane i at [i*DW +: DW]
//   mask_in      in   LANES               1 = store this lane
//   mem_we       out  1                   memory write request
//   mem_addr     out  ADDR_WIDTH          write address
//   mem_wdata    out  DATA_WIDTH          write data
//   mem_ready    in   1                   memory accepts the write this cycle
//   busy         out  1                   in WRITE or DONE
//   done         out  1                   one-cycle pulse, vector fully stored
// ---------------------------------------------------------------------------
module vector_store_serializer
    import vector_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LANES      = DEFAULT_LANES,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
`ifdef VSTORE_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0]       stride,
`endif
    input  logic [LANES*DATA_WIDTH-1:0] data_in,
    input  logic [LANES-1:0]            mask_in,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    input  logic                        mem_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    vstore_state_t                         state_q, state_d;
    logic [LANES-1:0]                      pending_q, pending_d;
    logic [LANES-1:0][DATA_WIDTH-1:0]      data_q, data_d;
    logic [ADDR_WIDTH-1:0]                 base_q, base_d;
    logic [IDX_W-1:0]                      k_q, k_d;
    logic                                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]                 mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]                 mem_wdata_q, mem_wdata_d;

    logic [LANES-1:0][DATA_WIDTH-1:0]      data_in_lanes;
    logic [LANES-1:0]                      enc_in;
    logic [LANES-1:0]                      cleared_mask;
    logic [IDX_W-1:0]                      enc_idx;
    logic                                  enc_any;
    logic [ADDR_WIDTH-1:0]                 stride_new;
    logic [ADDR_WIDTH-1:0]                 stride_cur;

    assign data_in_lanes = data_in;

    // The lane being presented is always pending, so dropping it leaves exactly
    // the lanes still owed to memory.
    assign cleared_mask = pending_q & ~(LANES'(1) << k_q);

`ifdef VSTORE_STRIDE_EN
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;

    assign stride_new = stride;
    assign stride_cur = stride_q;

    always_comb begin
        stride_d = stride_q;
        if (state_q == IDLE && start_valid) begin
            stride_d = stride;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stride_q <= '0;
        end else begin
            stride_q <= stride_d;
        end
    end
`else
    assign stride_new = ADDR_WIDTH'(1);
    assign stride_cur = ADDR_WIDTH'(1);
`endif

    // Address arithmetic is deliberately truncated: running past the top of
    // the address space wraps silently.
    function automatic logic [ADDR_WIDTH-1:0] lane_addr(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [IDX_W-1:0]      idx,
        input logic [ADDR_WIDTH-1:0] step
    );
        return base + ADDR_WIDTH'(idx) * step;
    endfunction

    // One encoder serves both the first lane (taken straight from the request)
    // and every following lane (taken from the mask with the current lane
    // removed), so the next write is ready in the register the cycle after
    // the previous one is accepted.
    lane_priority_encoder #(
        .LANES (LANES),
        .IDX_W (IDX_W)
    ) u_enc (
        .pending_i (enc_in),
        .index_o   (enc_idx),
        .any_o     (enc_any)
    );

    // Next-state logic. Memory-facing outputs are computed here one cycle
    // ahead and registered, so they stay put while the memory stalls.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        data_d      = data_q;
        base_d      = base_q;
        k_d         = k_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        enc_in      = cleared_mask;

        unique case (state_q)
            IDLE: begin
                enc_in = mask_in;
                if (start_valid) begin
                    pending_d = mask_in;
                    data_d    = data_in_lanes;
                    base_d    = base_addr;
                    if (enc_any) begin
                        state_d     = WRITE;
                        k_d         = enc_idx;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = lane_addr(base_addr, enc_idx, stride_new);
                        mem_wdata_d = data_in_lanes[enc_idx];
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    pending_d = cleared_mask;
                    if (enc_any) begin
                        k_d         = enc_idx;
                        mem_addr_d  = lane_addr(base_q, enc_idx, stride_cur);
                        mem_wdata_d = data_q[enc_idx];
                    end else begin
                        mem_we_d = 1'b0;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any store in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            data_q      <= '0;
            base_q      <= '0;
            k_q         <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            data_q      <= data_d;
            base_q      <= base_d;
            k_q         <= k_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_vector_store_serializer.sv
// ---------------------------------------------------------------------------
// tb_vector_store_serializer
// Self-checking bench for vector_store_serializer: a table of directed store
// requests with hand-computed write sequences, plus hand-written sequences
// for memory back-pressure, reset during a store, and the stride build.
// ---------------------------------------------------------------------------
module tb_vector_store_serializer;

    logic        clk;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] base_addr;
    logic [15:0] strideIn;
    logic [47:0] data_in;
    logic [5:0]  mask_in;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string             name;
        logic [15:0]       base;
        logic [15:0]       strd;
        logic [5:0]        mask;
        logic [47:0]       data;
        int                nWrites;
        logic [5:0][15:0]  expAddr;
        logic [5:0][7:0]   expData;
    } vecRec_t;

    vecRec_t vecs [5];

    vector_store_serializer dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .base_addr   (base_addr),
`ifdef VSTORE_STRIDE_EN
        .stride      (strideIn),
`endif
        .data_in     (data_in),
        .mask_in     (mask_in),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Presents one request at a negedge; returns at the next negedge, just
    // after the accepting edge, with the inputs scrambled to prove latching.
    task automatic applyStimulus(input logic [15:0] base, input logic [15:0] strd,
                                 input logic [5:0] mask, input logic [47:0] data);
        checkOutput("start_ready_before_req", start_ready, 1);
        base_addr   = base;
        strideIn    = strd;
        mask_in     = mask;
        data_in     = data;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        base_addr   = 16'hDEAD;
        strideIn    = 16'h0007;
        mask_in     = 6'h3F;
        data_in     = {6{8'hEE}};
    endtask

    // Runs one table record with the memory always ready: every write must
    // match the expected list and arrive on consecutive cycles.
    task automatic runVector(input vecRec_t v);
        int n   = 0;
        int cyc = 0;
        bit seen = 1'b0;
        mem_ready = 1'b1;
        applyStimulus(v.base, v.strd, v.mask, v.data);
        while (!seen && cyc <= 12) begin
            if (done) begin
                seen = 1'b1;
                checkOutput({v.name, "_done_we"}, mem_we, 0);
                checkOutput({v.name, "_done_busy"}, busy, 1);
            end else begin
                if (mem_we) begin
                    if (n < 6) begin
                        checkOutput({v.name, "_addr"}, mem_addr, v.expAddr[n]);
                        checkOutput({v.name, "_wdata"}, mem_wdata, v.expData[n]);
                    end
                    n++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput({v.name, "_done_seen"}, seen, 1);
        checkOutput({v.name, "_write_count"}, n, v.nWrites);
        checkOutput({v.name, "_latency"}, cyc, v.nWrites);
        @(negedge clk);
        checkOutput({v.name, "_done_single"}, done, 0);
        checkOutput({v.name, "_ready_back"}, start_ready, 1);
    endtask

    initial begin
        int weCount;
        vecRec_t sv;

        vecs[0] = '{"full", 16'h0100, 16'h0001, 6'b111111, 48'h050403020100, 6,
                    {16'h0105, 16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100},
                    {8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00}};
        vecs[1] = '{"sparse", 16'h0020, 16'h0001, 6'b100101, 48'hA5B4C3D2E1F0, 3,
                    {16'h0, 16'h0, 16'h0, 16'h0025, 16'h0022, 16'h0020},
                    {8'h0, 8'h0, 8'h0, 8'hA5, 8'hD2, 8'hF0}};
        vecs[2] = '{"zero", 16'h1234, 16'h0001, 6'b000000, 48'hFFFFFFFFFFFF, 0,
                    {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                    {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}};
        vecs[3] = '{"wrap", 16'hFFFE, 16'h0001, 6'b000111, 48'h665544332211, 3,
                    {16'h0, 16'h0, 16'h0, 16'h0000, 16'hFFFF, 16'hFFFE},
                    {8'h0, 8'h0, 8'h0, 8'h33, 8'h22, 8'h11}};
        vecs[4] = '{"upper", 16'h0300, 16'h0001, 6'b110000, 48'h998877665544, 2,
                    {16'h0, 16'h0, 16'h0, 16'h0, 16'h0305, 16'h0304},
                    {8'h0, 8'h0, 8'h0, 8'h0, 8'h99, 8'h88}};

        reset       = 1'b1;
        start_valid = 1'b0;
        base_addr   = '0;
        strideIn    = 16'h0001;
        data_in     = '0;
        mask_in     = '0;
        mem_ready   = 1'b1;
        repeat (2) @(negedge clk);

        checkOutput("reset_start_ready", start_ready, 1);
        checkOutput("reset_mem_we", mem_we, 0);
        checkOutput("reset_mem_addr", mem_addr, 0);
        checkOutput("reset_mem_wdata", mem_wdata, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            runVector(vecs[i]);
        end

        // Back-pressure: first write stalls for three cycles; the held write
        // and everything after it must ignore the scrambled inputs and a new
        // start_valid while busy.
        mem_ready = 1'b0;
        applyStimulus(16'h0040, 16'h0001, 6'b000011, 48'h00000000BBAA);
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_hold_we", mem_we, 1);
            checkOutput("bp_hold_addr", mem_addr, 16'h0040);
            checkOutput("bp_hold_wdata", mem_wdata, 8'hAA);
            checkOutput("bp_busy", busy, 1);
            checkOutput("bp_no_ready", start_ready, 0);
            start_valid = 1'b1;
            if (i == 3) begin
                mem_ready   = 1'b1;
                start_valid = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput("bp_second_we", mem_we, 1);
        checkOutput("bp_second_addr", mem_addr, 16'h0041);
        checkOutput("bp_second_wdata", mem_wdata, 8'hBB);
        checkOutput("bp_second_done", done, 0);
        @(negedge clk);
        checkOutput("bp_done", done, 1);
        checkOutput("bp_done_we", mem_we, 0);
        @(negedge clk);
        checkOutput("bp_done_single", done, 0);
        checkOutput("bp_ready_back", start_ready, 1);

        // Reset during the second write of a wrapping store.
        mem_ready = 1'b1;
        applyStimulus(16'hFFFE, 16'h0001, 6'b000111, 48'h665544332211);
        checkOutput("rst_first_addr", mem_addr, 16'hFFFE);
        @(negedge clk);
        checkOutput("rst_second_we", mem_we, 1);
        checkOutput("rst_second_addr", mem_addr, 16'hFFFF);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_mid_mem_we", mem_we, 0);
        checkOutput("rst_mid_mem_addr", mem_addr, 0);
        checkOutput("rst_mid_mem_wdata", mem_wdata, 0);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_done", done, 0);
        checkOutput("rst_mid_start_ready", start_ready, 1);
        @(negedge clk);
        reset   = 1'b0;
        weCount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_we || done) weCount++;
        end
        checkOutput("rst_no_more_writes", weCount, 0);
        checkOutput("rst_idle_ready", start_ready, 1);

`ifdef VSTORE_STRIDE_EN
        sv = '{"stride", 16'h0010, 16'h0004, 6'b001011, 48'h000044332211, 3,
               {16'h0, 16'h0, 16'h0, 16'h001C, 16'h0014, 16'h0010},
               {8'h0, 8'h0, 8'h0, 8'h44, 8'h22, 8'h11}};
        runVector(sv);
        sv = '{"stride0", 16'h0050, 16'h0000, 6'b000101, 48'h0000003300AA, 2,
               {16'h0, 16'h0, 16'h0, 16'h0, 16'h0050, 16'h0050},
               {8'h0, 8'h0, 8'h0, 8'h0, 8'h33, 8'hAA}};
        runVector(sv);
`else
        sv = vecs[0];
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
